stream_packer: RTL and testbench

- Upsizing stage that sits directly downstream of skid_buffer.
- Packs RATIO consecutive DATA_WIDTH-bit valid/ready beats into one DATA_WIDTH*RATIO-bit output word.
- Emits a partial word early when the upstream marks a beat as last; out_keep flags which lanes of that word hold data.
- Both sides use the same valid/ready handshake as the rest of the stream fabric.

---
 rtl/stream_packer_if.sv | 34 +++
 rtl/stream_packer.sv | 97 +++++++++
 tb/tb_stream_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_packer_if.sv
// ----------------------------------------------------------------
// stream_packer_if : narrow input stream and packed output stream
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface stream_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
);
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_last;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]            out_keep;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  // Environment side: drives the narrow beats and the downstream ready.
  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );

  // Packer side.
  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/stream_packer.sv
// ----------------------------------------------------------------
// stream_packer : packs RATIO narrow beats into one wide word, early on last
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  wire            clk,
  input  wire            areset,
  stream_packer_if.slave bus
);
  localparam int                 c_cnt_w     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("stream_packer: RATIO must be at least 2");
  end

  logic [c_cnt_w-1:0]          r_cnt;
  logic [DATA_WIDTH*RATIO-1:0] r_acc;
  logic [RATIO-1:0]            r_mask;
  logic [DATA_WIDTH*RATIO-1:0] r_out_data;
  logic [RATIO-1:0]            r_out_keep;
  logic                        r_out_last;
  logic                        r_out_valid;

  logic                        w_in_ready;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_complete;
  logic [RATIO-1:0]            w_lane_sel;
  logic [RATIO-1:0]            w_mask_next;
  logic [DATA_WIDTH*RATIO-1:0] w_acc_next;

  // Ready depends only on registered state and out_ready, so a consumed
  // word frees the stage in the same cycle without a bubble.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  always_comb begin
    w_lane_sel = '0;
    w_acc_next = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (r_cnt == c_cnt_w'(k)) begin
        w_lane_sel[k]                            = 1'b1;
        w_acc_next[k*DATA_WIDTH +: DATA_WIDTH]   = bus.in_data;
      end
    end
  end

  assign w_mask_next = r_mask | w_lane_sel;
  assign w_complete  = w_in_fire && ((r_cnt == c_last_lane) || bus.in_last);

  // The accumulator is cleared after every word, so lanes never written
  // for a short packet are already zero when the word is emitted.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mask      <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_keep  <= w_mask_next;
      r_out_last  <= bus.in_last;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mask      <= '0;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_acc  <= w_acc_next;
        r_mask <= w_mask_next;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_keep  = r_out_keep;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
// ----------------------------------------------------------------
// tb_stream_packer : directed stimulus, queue-based packing model, literal pins
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_stream_packer;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic clk;
  logic areset;

  stream_packer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

  stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  word_t         exp_q[$];
  logic [DW-1:0] part[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: beats gather in a queue; a word is formed when RATIO beats are
  // held or a last beat arrives, and it must appear one edge later and stay
  // presented until the downstream takes it.
  always @(negedge clk) begin
    if (areset) begin
      exp_q.delete();
      part.delete();
      chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_data",  {32'd0, bus.out_data},  64'd0);
      chk("rst_keep",  {60'd0, bus.out_keep},  64'd0);
      chk("rst_last",  {63'd0, bus.out_last},  64'd0);
    end else begin
      automatic logic exp_valid = (exp_q.size() > 0);
      automatic logic exp_rdy   = !exp_valid || bus.out_ready;
      chk("m_valid", {63'd0, bus.out_valid}, {63'd0, exp_valid});
      chk("m_in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
      if (exp_valid) begin
        chk("m_data", {32'd0, bus.out_data}, {32'd0, exp_q[0].data});
        chk("m_keep", {60'd0, bus.out_keep}, {60'd0, exp_q[0].keep});
        chk("m_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].last});
      end
      if (exp_valid && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && exp_rdy) begin
        part.push_back(bus.in_data);
        if (part.size() == R || bus.in_last) begin
          automatic word_t w;
          w.data = '0;
          w.keep = '0;
          for (int i = 0; i < part.size(); i++) begin
            w.data[i*DW +: DW] = part[i];
            w.keep[i] = 1'b1;
          end
          w.last = bus.in_last;
          exp_q.push_back(w);
          part.delete();
        end
      end
    end
  end

  // Present a beat and hold it until the edge that accepts it.
  task automatic send(input logic [DW-1:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic chk_word(input string name, input logic [OW-1:0] d,
                          input logic [R-1:0] k, input logic l);
    chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({name, "_data"},  {32'd0, bus.out_data},  {32'd0, d});
    chk({name, "_keep"},  {60'd0, bus.out_keep},  {60'd0, k});
    chk({name, "_last"},  {63'd0, bus.out_last},  {63'd0, l});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    #1 areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_data",  {32'd0, bus.out_data},  64'd0);
    areset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Full packet, last on the fourth beat.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    idle();
    chk_word("full", 32'h44332211, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    chk("full_one_cycle", {63'd0, bus.out_valid}, 64'd0);

    // Short packet.
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    idle();
    chk_word("short", 32'h0000A2A1, 4'b0011, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back streaming, no bubbles.
    for (int i = 1; i <= 12; i++) begin
      send(DW'(i), 1'b0);
      chk("stream_rdy", {63'd0, bus.in_ready}, 64'd1);
      if (i == 4)  chk_word("stream0", 32'h04030201, 4'b1111, 1'b0);
      if (i == 8)  chk_word("stream1", 32'h08070605, 4'b1111, 1'b0);
      if (i == 12) chk_word("stream2", 32'h0C0B0A09, 4'b1111, 1'b0);
    end
    idle();
    @(posedge clk);
    #1;

    // Stall with a beat waiting.
    bus.out_ready = 1'b0;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    bus.in_data  = 8'h71;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rdy",  {63'd0, bus.in_ready}, 64'd0);
      chk("stall_data", {32'd0, bus.out_data}, 64'h64636261);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(8'h71, 1'b0);
    chk("stall_drain", {63'd0, bus.out_valid}, 64'd0);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    send(8'h74, 1'b1);
    idle();
    chk_word("after_stall", 32'h74737271, 4'b1111, 1'b1);
    @(posedge clk);
    #1;

    // Single-beat packet.
    send(8'h5A, 1'b1);
    idle();
    chk_word("single", 32'h0000005A, 4'b0001, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of a word discards the partial lanes.
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    idle();
    areset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(posedge clk);
    #1;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    idle();
    chk_word("post_rst", 32'hC4C3C2C1, 4'b1111, 1'b0);
    @(posedge clk);
    #1;

    // Reset with a word held by backpressure clears it immediately.
    bus.out_ready = 1'b0;
    send(8'hD1, 1'b1);
    idle();
    chk_word("held", 32'h000000D1, 4'b0001, 1'b1);
    areset = 1'b1;
    #1;
    chk("held_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("held_rst_data",  {32'd0, bus.out_data},  64'd0);
    chk("held_rst_keep",  {60'd0, bus.out_keep},  64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
